pipelined_control_decoder: RTL
==============================

# pipelined_control_decoder

Registered RISC-V control decoder for the pipelined core. It decodes the instruction held in the IF/ID register and captures the control bundle into the ID/EX control register. It detects load-use hazards against the instruction already in Execute and inserts bubbles. Relative to the single-cycle decoder it adds XLEN-parametrised RV64 word-op decode, flush/hold handling and optional illegal-instruction tracking.

## Interface
- XLEN, 32, datapath width; only 32 or 64 legal; 64 enables OP-IMM-32 (0011011) and OP-32 (0111011) decode
- CNT_W, 8, width of illegal-instruction counter
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- instr_d  in  32  instruction in Decode
- valid_d  in  1  instr_d is a real instruction
- flush_e  in  1  squash: load bubble into ID/EX
- hold_e  in  1  freeze ID/EX register (downstream stall)
- stall_fd  out  1  combinational; hold PC and IF/ID (load-use)
- valid_e  out  1  ID/EX holds a real instruction
- reg_write_e, mem_write_e, branch_e, jump_e, control_e_adder_e, word_op_e  out  1 each  registered controls
- alu_src_b_e  out  3;  result_src_e  out  2;  alu_op_e  out  2;  branch_sel_e  out  3;  imm_src_e  out  3
- rd_e, rs1_e, rs2_e  out  5 each;  funct3_e  out  3
- illegal_e  out  1  ID/EX instruction is illegal
- illegal_count  out  CNT_W  saturating count of illegal instructions entering E

## Operation
- Decode (fields not listed are 0; rw=reg_write, mw=mem_write, asb=alu_src_b, rs=result_src, aop=alu_op, imm=imm_src):
- R 0110011: rw=1, asb=000, rs=00, aop=10
- I 0010011: rw=1, asb=010, aop=10; imm=011 if funct3 is 001 or 101, else 000
- LOAD 0000011: rw=1, asb=010, rs=01, aop=00, imm=000
- STORE 0100011: mw=1, asb=010, aop=00, imm=010
- BRANCH 1100011: branch=1, aop=01, imm=001; branch_sel by funct3: 000→0, 001→1, 100→2, 101→3, 110→4, 111→5, others→0
- JAL 1101111: rw=1, jump=1, rs=10, imm=101
- JALR 1100111: rw=1, jump=1, rs=10, imm=000, control_e_adder=1
- LUI 0110111: rw=1, asb=110, aop=10, imm=100
- AUIPC 0010111: same as LUI but aop=11
- OP-IMM-32 / OP-32 (XLEN=64 only): as I / R respectively, word_op=1
- Unknown opcode: all controls 0
- Operand use: rs1 is used by every opcode except LUI, AUIPC and JAL. rs2 is used by R, OP-32, BRANCH and STORE.
- Load-use hazard, lu = valid_e & result_src_e==01 & rd_e!=0 & valid_d & ((uses_rs1 & rs1_d==rd_e) | (uses_rs2 & rs2_d==rd_e)).
- stall_fd = lu & ~flush_e.
- Bubble: valid_e=0 and all controls, rd/rs/funct3, word_op_e and illegal_e are 0.

## Timing
- Reset: every output 0; illegal_count=0.
- ID/EX update priority on each clk edge:
  1. reset
  2. flush_e (bubble)
  3. hold_e (retain all)
  4. lu (bubble)
  5. otherwise load the decode of instr_d, with valid_e=valid_d; an invalid instruction loads as a bubble
- Latency: one cycle from instr_d to *_e outputs.
- With hold_e=1 and lu=1, stall_fd stays asserted and the bubble is inserted on the first cycle with hold_e=0.
- flush_e overrides both hold and stall in the same cycle.
- Reset asserted mid-stall clears state; stall_fd=0 the following cycle.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - Illegal means any of: instr_d[1:0]!=11, an unknown opcode (including the word opcodes when XLEN=32), or BRANCH funct3 010/011.
  - An illegal instruction loads with valid_e=1 and illegal_e=1; rw, mw, branch and jump are forced to 0.
  - illegal_count increments, saturating at all-ones, on each non-bubble load of an illegal instruction. It does not increment under hold, flush or lu.
- Undefined: illegal_e and illegal_count are tied to 0 and no counter flops exist.

## Structure
- decode_pkg holds:
  - opcode localparams
  - ctrl_t packed struct (all control fields)
  - branch_sel enum
  - CTRL_BUBBLE constant
- Sub-module decode_ctrl_comb: a purely combinational instr→ctrl_t decode plus uses_rs1 and uses_rs2. This top module adds the hazard logic, the ID/EX register and the counter.

## Test plan
- Reset, then drive valid ADDI x1,x0,5 (0x00500093) → next cycle valid_e=1, rw=1, asb=010, aop=10, imm=000, rd_e=1.
- LW x2,0(x1) followed by ADD x3,x2,x2 → stall_fd=1 for one cycle, one bubble (valid_e=0), then ADD in E.
- Same sequence with rd=x0 → no stall; LW x2 followed by LUI x5 → no stall.
- hold_e=1 for 3 cycles with BNE in E → outputs stable with branch_sel_e=1. flush_e during the hold → bubble on the next edge.
- XLEN=64: ADDW (0x002081BB) → word_op_e=1, aop=10. XLEN=32 with the macro on: same word → illegal_e=1, rw=0.
- Macro on, CNT_W=2, five illegal words (0x00000000) in sequence → illegal_count 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, control bundle and branch-select encoding for the pipelined decoder
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd2,
        BR_GE  = 3'd3,
        BR_LTU = 3'd4,
        BR_GEU = 3'd5
    } branch_sel_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        control_e_adder;
        logic        word_op;
        logic [2:0]  alu_src_b;
        logic [1:0]  result_src;
        logic [1:0]  alu_op;
        branch_sel_t branch_sel;
        logic [2:0]  imm_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic branch_sel_t branch_sel_of(input logic [2:0] funct3);
        case (funct3)
            3'b001:  return BR_NE;
            3'b100:  return BR_LT;
            3'b101:  return BR_GE;
            3'b110:  return BR_LTU;
            3'b111:  return BR_GEU;
            default: return BR_EQ;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// rtl/decode_ctrl_comb.sv - combinational opcode/funct3 to control bundle decode with operand-use flags
module decode_ctrl_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output ctrl_t      o_ctrl,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_illegal
);

    logic w_known;

    always_comb begin
        o_ctrl     = CTRL_BUBBLE;
        o_uses_rs2 = 1'b0;
        w_known    = 1'b1;
        case (i_opcode)
            OP_R: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = 2'b10;
                o_uses_rs2       = 1'b1;
            end
            OP_I: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src_b = 3'b010;
                o_ctrl.alu_op    = 2'b10;
                o_ctrl.imm_src   = (i_funct3 == 3'b001 || i_funct3 == 3'b101) ? 3'b011 : 3'b000;
            end
            OP_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src_b  = 3'b010;
                o_ctrl.result_src = 2'b01;
            end
            OP_STORE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src_b = 3'b010;
                o_ctrl.imm_src   = 3'b010;
                o_uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.branch     = 1'b1;
                o_ctrl.alu_op     = 2'b01;
                o_ctrl.imm_src    = 3'b001;
                o_ctrl.branch_sel = branch_sel_of(i_funct3);
                o_uses_rs2        = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.jump       = 1'b1;
                o_ctrl.result_src = 2'b10;
                o_ctrl.imm_src    = 3'b101;
            end
            OP_JALR: begin
                o_ctrl.reg_write       = 1'b1;
                o_ctrl.jump            = 1'b1;
                o_ctrl.result_src      = 2'b10;
                o_ctrl.control_e_adder = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src_b = 3'b110;
                o_ctrl.alu_op    = (i_opcode == OP_AUIPC) ? 2'b11 : 2'b10;
                o_ctrl.imm_src   = 3'b100;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.word_op   = 1'b1;
                    o_ctrl.alu_src_b = 3'b010;
                    o_ctrl.alu_op    = 2'b10;
                    o_ctrl.imm_src   = (i_funct3 == 3'b001 || i_funct3 == 3'b101) ? 3'b011 : 3'b000;
                end else begin
                    w_known = 1'b0;
                end
            end
            OP_32: begin
                if (XLEN == 64) begin
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.word_op   = 1'b1;
                    o_ctrl.alu_op    = 2'b10;
                    o_uses_rs2       = 1'b1;
                end else begin
                    w_known = 1'b0;
                end
            end
            default: w_known = 1'b0;
        endcase
    end

    assign o_uses_rs1 = !(i_opcode == OP_LUI || i_opcode == OP_AUIPC || i_opcode == OP_JAL);

    // opcode[1:0] is the compressed-encoding marker; branch funct3 010/011 is unassigned
    assign o_illegal = (i_opcode[1:0] != 2'b11) || !w_known ||
                       (i_opcode == OP_BRANCH && i_funct3[2:1] == 2'b01);

endmodule

// File: rtl/pipelined_control_decoder.sv
// rtl/pipelined_control_decoder.sv - ID/EX control register with load-use stall; illegal tracking under DECODE_ILLEGAL_TRAP_EN
module pipelined_control_decoder
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_d,
    input  logic             valid_d,
    input  logic             flush_e,
    input  logic             hold_e,
    output logic             stall_fd,
    output logic             valid_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic             control_e_adder_e,
    output logic             word_op_e,
    output logic [2:0]       alu_src_b_e,
    output logic [1:0]       result_src_e,
    output logic [1:0]       alu_op_e,
    output logic [2:0]       branch_sel_e,
    output logic [2:0]       imm_src_e,
    output logic [4:0]       rd_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [2:0]       funct3_e,
    output logic             illegal_e,
    output logic [CNT_W-1:0] illegal_count
);

    ctrl_t       w_dec_ctrl;
    ctrl_t       w_load_ctrl;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_dec_illegal;
    logic        w_lu;
    logic        w_en;
    logic        w_bubble;
    logic        w_unused;

    ctrl_t       r_ctrl;
    logic        r_valid;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_funct3;

    decode_ctrl_comb #(.XLEN(XLEN)) u_dec (
        .i_opcode   (instr_d[6:0]),
        .i_funct3   (instr_d[14:12]),
        .o_ctrl     (w_dec_ctrl),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_illegal  (w_dec_illegal)
    );

    assign w_lu = r_valid && (r_ctrl.result_src == 2'b01) && (r_rd != 5'd0) && valid_d &&
                  ((w_uses_rs1 && instr_d[19:15] == r_rd) || (w_uses_rs2 && instr_d[24:20] == r_rd));

    assign stall_fd = w_lu && !flush_e;

    // flush beats hold; hold beats the load-use bubble so the stall persists until release
    assign w_en     = flush_e || !hold_e;
    assign w_bubble = flush_e || w_lu || !valid_d;

    always_comb begin
        w_load_ctrl = w_dec_ctrl;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (w_dec_illegal) begin
            w_load_ctrl.reg_write = 1'b0;
            w_load_ctrl.mem_write = 1'b0;
            w_load_ctrl.branch    = 1'b0;
            w_load_ctrl.jump      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_ctrl   <= CTRL_BUBBLE;
            r_rd     <= 5'd0;
            r_rs1    <= 5'd0;
            r_rs2    <= 5'd0;
            r_funct3 <= 3'd0;
        end else if (w_en) begin
            if (w_bubble) begin
                r_valid  <= 1'b0;
                r_ctrl   <= CTRL_BUBBLE;
                r_rd     <= 5'd0;
                r_rs1    <= 5'd0;
                r_rs2    <= 5'd0;
                r_funct3 <= 3'd0;
            end else begin
                r_valid  <= 1'b1;
                r_ctrl   <= w_load_ctrl;
                r_rd     <= instr_d[11:7];
                r_rs1    <= instr_d[19:15];
                r_rs2    <= instr_d[24:20];
                r_funct3 <= instr_d[14:12];
            end
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             r_illegal;
    logic [CNT_W-1:0] r_illegal_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal       <= 1'b0;
            r_illegal_count <= '0;
        end else if (w_en) begin
            r_illegal <= !w_bubble && w_dec_illegal;
            if (!w_bubble && w_dec_illegal && r_illegal_count != {CNT_W{1'b1}})
                r_illegal_count <= r_illegal_count + 1'b1;
        end
    end

    assign illegal_e     = r_illegal;
    assign illegal_count = r_illegal_count;
    assign w_unused      = ^instr_d[31:25];
`else
    assign illegal_e     = 1'b0;
    assign illegal_count = '0;
    assign w_unused      = ^{instr_d[31:25], w_dec_illegal};
`endif

    assign valid_e           = r_valid;
    assign reg_write_e       = r_ctrl.reg_write;
    assign mem_write_e       = r_ctrl.mem_write;
    assign branch_e          = r_ctrl.branch;
    assign jump_e            = r_ctrl.jump;
    assign control_e_adder_e = r_ctrl.control_e_adder;
    assign word_op_e         = r_ctrl.word_op;
    assign alu_src_b_e       = r_ctrl.alu_src_b;
    assign result_src_e      = r_ctrl.result_src;
    assign alu_op_e          = r_ctrl.alu_op;
    assign branch_sel_e      = r_ctrl.branch_sel;
    assign imm_src_e         = r_ctrl.imm_src;
    assign rd_e              = r_rd;
    assign rs1_e             = r_rs1;
    assign rs2_e             = r_rs2;
    assign funct3_e          = r_funct3;

endmodule
